data_memory_arbiter: RTL and testbench

// - Shares the single-port data memory between the core load/store path and a debug/loader port.
// - Sits between core execute-stage memory signals and the data memory; drives core_stall so the pipeline holds while a core access waits or is in flight.
// - Round-robin between the two requesters; fixed-latency memory sequenced by an internal FSM.

---
 rtl/data_memory_arbiter.sv | 159 +++++++++++++++
 tb/tb_data_memory_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port data memory between the core
// load/store path and a debug/loader port; stalls the core while its access waits or runs.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module data_memory_arbiter #(
   parameter int unsigned ADDR_WIDTH  = `ADDRESS_SIZE,
   parameter int unsigned DATA_WIDTH  = `DATA_SIZE,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  core_req,
   input  logic                  core_write,
   input  logic [ADDR_WIDTH-1:0] core_address,
   input  logic [DATA_WIDTH-1:0] core_data_out,
   output logic [DATA_WIDTH-1:0] core_data_in,
   output logic                  core_ack,
   output logic                  core_stall,
   input  logic                  dbg_req,
   input  logic                  dbg_write,
   input  logic [ADDR_WIDTH-1:0] dbg_address,
   input  logic [DATA_WIDTH-1:0] dbg_data_out,
   output logic [DATA_WIDTH-1:0] dbg_data_in,
   output logic                  dbg_ack,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e                state_q, state_d;
   logic                  last_dbg_q, last_dbg_d;
   logic                  gnt_dbg_q, gnt_dbg_d;
   logic                  wr_q, wr_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
   logic [DATA_WIDTH-1:0] mem_data_out_q, mem_data_out_d;
   logic [DATA_WIDTH-1:0] core_data_in_q, core_data_in_d;
   logic [DATA_WIDTH-1:0] dbg_data_in_q, dbg_data_in_d;
   logic                  core_ack_q, core_ack_d;
   logic                  dbg_ack_q, dbg_ack_d;
   logic                  busy_q, busy_d;
   logic                  pick_dbg;

   // Debug wins only when alone, or when both ask and the core was served last.
   assign pick_dbg = dbg_req & ~(core_req & last_dbg_q);

   always_comb begin
      state_d        = state_q;
      last_dbg_d     = last_dbg_q;
      gnt_dbg_d      = gnt_dbg_q;
      wr_d           = wr_q;
      cnt_d          = cnt_q;
      mem_read_d     = mem_read_q;
      mem_write_d    = mem_write_q;
      mem_address_d  = mem_address_q;
      mem_data_out_d = mem_data_out_q;
      core_data_in_d = core_data_in_q;
      dbg_data_in_d  = dbg_data_in_q;
      core_ack_d     = 1'b0;
      dbg_ack_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (core_req || dbg_req) begin
               gnt_dbg_d      = pick_dbg;
               last_dbg_d     = pick_dbg;
               wr_d           = pick_dbg ? dbg_write : core_write;
               mem_address_d  = pick_dbg ? dbg_address : core_address;
               mem_data_out_d = pick_dbg ? dbg_data_out : core_data_out;
               mem_read_d     = ~wr_d;
               mem_write_d    = wr_d;
               cnt_d          = 4'(MEM_LATENCY - 1);
               state_d        = StAccess;
            end
         end
         StAccess: begin
            if (cnt_q == 4'd0) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (!wr_q) begin
                  if (gnt_dbg_q) dbg_data_in_d = mem_data_in;
                  else           core_data_in_d = mem_data_in;
               end
               core_ack_d = ~gnt_dbg_q;
               dbg_ack_d  = gnt_dbg_q;
               state_d    = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d     = StIdle;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         last_dbg_q     <= 1'b1;
         gnt_dbg_q      <= 1'b0;
         wr_q           <= 1'b0;
         cnt_q          <= 4'd0;
         mem_read_q     <= 1'b0;
         mem_write_q    <= 1'b0;
         mem_address_q  <= '0;
         mem_data_out_q <= '0;
         core_data_in_q <= '0;
         dbg_data_in_q  <= '0;
         core_ack_q     <= 1'b0;
         dbg_ack_q      <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_dbg_q     <= last_dbg_d;
         gnt_dbg_q      <= gnt_dbg_d;
         wr_q           <= wr_d;
         cnt_q          <= cnt_d;
         mem_read_q     <= mem_read_d;
         mem_write_q    <= mem_write_d;
         mem_address_q  <= mem_address_d;
         mem_data_out_q <= mem_data_out_d;
         core_data_in_q <= core_data_in_d;
         dbg_data_in_q  <= dbg_data_in_d;
         core_ack_q     <= core_ack_d;
         dbg_ack_q      <= dbg_ack_d;
         busy_q         <= busy_d;
      end
   end

   assign core_data_in = core_data_in_q;
   assign dbg_data_in  = dbg_data_in_q;
   assign core_ack     = core_ack_q;
   assign dbg_ack      = dbg_ack_q;
   assign core_stall   = core_req & ~core_ack_q;
   assign mem_read     = mem_read_q;
   assign mem_write    = mem_write_q;
   assign mem_address  = mem_address_q;
   assign mem_data_out = mem_data_out_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: a MEM_LATENCY=2 instance for arbitration, stores
// and reset, plus a MEM_LATENCY=1 instance for back-to-back core loads.
module tb_data_memory_arbiter;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          core_req, core_write, dbg_req, dbg_write;
   logic [AW-1:0] core_address, dbg_address, mem_address;
   logic [DW-1:0] core_data_out, dbg_data_out, core_data_in, dbg_data_in;
   logic [DW-1:0] mem_data_out, mem_data_in;
   logic          core_ack, core_stall, dbg_ack, mem_read, mem_write, busy;

   // Second instance (latency 1): only the core port is exercised.
   logic          c1_req;
   logic [AW-1:0] c1_address, m1_address;
   logic [DW-1:0] c1_data_in, m1_data_out, m1_data_in, d1_data_in;
   logic          c1_ack, c1_stall, d1_ack, m1_read, m1_write, busy1;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   // Memory model for the latency-1 instance: data is 0xA5 above the address.
   assign m1_data_in = {8'hA5, m1_address};

   data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(2)) dut (
      .clock(clock), .reset(reset),
      .core_req(core_req), .core_write(core_write), .core_address(core_address),
      .core_data_out(core_data_out), .core_data_in(core_data_in), .core_ack(core_ack),
      .core_stall(core_stall),
      .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_address(dbg_address),
      .dbg_data_out(dbg_data_out), .dbg_data_in(dbg_data_in), .dbg_ack(dbg_ack),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .busy(busy)
   );

   data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) dut1 (
      .clock(clock), .reset(reset),
      .core_req(c1_req), .core_write(1'b0), .core_address(c1_address),
      .core_data_out(16'h0000), .core_data_in(c1_data_in), .core_ack(c1_ack),
      .core_stall(c1_stall),
      .dbg_req(1'b0), .dbg_write(1'b0), .dbg_address(8'h00),
      .dbg_data_out(16'h0000), .dbg_data_in(d1_data_in), .dbg_ack(d1_ack),
      .mem_read(m1_read), .mem_write(m1_write), .mem_address(m1_address),
      .mem_data_out(m1_data_out), .mem_data_in(m1_data_in), .busy(busy1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      core_req = 0; core_write = 0; core_address = '0; core_data_out = '0;
      dbg_req = 0; dbg_write = 0; dbg_address = '0; dbg_data_out = '0;
      mem_data_in = '0; c1_req = 0; c1_address = '0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_strobes", {mem_read, mem_write}, 0);
      check("rst_acks", {core_ack, dbg_ack}, 0);
      check("rst_data", {core_data_in, dbg_data_in}, 0);
      reset = 1'b1;
      tick();

      // Core load from 0x05, memory returns 0xBEEF.
      core_req = 1; core_write = 0; core_address = 8'h05; mem_data_in = 16'hBEEF;
      #1;
      check("ld_stall_idle", core_stall, 1);
      tick();
      check("ld_acc1_rd", {mem_read, mem_write}, 2'b10);
      check("ld_acc1_addr", mem_address, 8'h05);
      check("ld_acc1_busy", busy, 1);
      tick();
      check("ld_acc2_rd", {mem_read, mem_write}, 2'b10);
      check("ld_acc2_stall", core_stall, 1);
      tick();
      check("ld_done_rd", mem_read, 0);
      check("ld_done_ack", {core_ack, dbg_ack}, 2'b10);
      check("ld_done_data", core_data_in, 16'hBEEF);
      check("ld_done_stall", core_stall, 0);
      tick();
      core_req = 0;
      check("ld_idle_ack", core_ack, 0);
      check("ld_idle_busy", busy, 0);

      // Debug store 0x1234 to 0x3F.
      dbg_req = 1; dbg_write = 1; dbg_address = 8'h3F; dbg_data_out = 16'h1234;
      #1;
      check("st_core_stall", core_stall, 0);
      tick();
      check("st_acc1_wr", {mem_read, mem_write}, 2'b01);
      check("st_acc1_addr", mem_address, 8'h3F);
      check("st_acc1_data", mem_data_out, 16'h1234);
      tick();
      check("st_acc2_wr", {mem_read, mem_write}, 2'b01);
      tick();
      check("st_done_wr", {mem_read, mem_write}, 2'b00);
      check("st_done_ack", {core_ack, dbg_ack}, 2'b01);
      check("st_done_dbgdata", dbg_data_in, 16'h0000);
      tick();
      dbg_req = 0; dbg_write = 0;
      check("st_idle_ack", dbg_ack, 0);

      // Reset, then core and debug request together: core, dbg, core, dbg.
      reset = 1'b0; tick(); reset = 1'b1;
      core_req = 1; core_address = 8'h10; dbg_req = 1; dbg_address = 8'h20;
      mem_data_in = 16'hC0DE;
      tick();
      check("rr1_addr", mem_address, 8'h10);
      tick(); tick();
      check("rr1_ack", {core_ack, dbg_ack}, 2'b10);
      check("rr1_data", core_data_in, 16'hC0DE);
      check("rr1_dbg_wait", busy, 1);
      tick();
      core_address = 8'h11; mem_data_in = 16'hD00D;
      tick();
      check("rr2_addr", mem_address, 8'h20);
      tick(); tick();
      check("rr2_ack", {core_ack, dbg_ack}, 2'b01);
      check("rr2_data", dbg_data_in, 16'hD00D);
      check("rr2_core_stall", core_stall, 1);
      tick();
      dbg_address = 8'h21;
      tick();
      check("rr3_addr", mem_address, 8'h11);
      tick(); tick();
      check("rr3_ack", {core_ack, dbg_ack}, 2'b10);
      check("rr3_data", core_data_in, 16'hD00D);
      tick();
      core_req = 0;
      tick();
      check("rr4_addr", mem_address, 8'h21);
      tick(); tick();
      check("rr4_ack", {core_ack, dbg_ack}, 2'b01);
      tick();
      dbg_req = 0;

      // Core request arrives while debug access is in flight.
      dbg_req = 1; dbg_write = 0; dbg_address = 8'h30; mem_data_in = 16'h5555;
      tick();
      core_req = 1; core_write = 0; core_address = 8'h31;
      #1;
      check("late_stall_acc1", core_stall, 1);
      tick();
      check("late_stall_acc2", core_stall, 1);
      tick();
      check("late_dbg_ack", {core_ack, dbg_ack}, 2'b01);
      check("late_stall_done", core_stall, 1);
      tick();
      dbg_req = 0; mem_data_in = 16'h6666;
      check("late_idle_busy", busy, 0);
      check("late_idle_stall", core_stall, 1);
      tick();
      check("late_core_addr", mem_address, 8'h31);
      check("late_core_rd", mem_read, 1);
      tick(); tick();
      check("late_core_ack", {core_ack, dbg_ack}, 2'b10);
      check("late_core_data", core_data_in, 16'h6666);
      check("late_stall_end", core_stall, 0);
      tick();
      core_req = 0;

      // Reset during second ACCESS cycle abandons the access.
      core_req = 1; core_address = 8'h07; mem_data_in = 16'h7777;
      tick(); tick();
      check("ra_acc2_rd", mem_read, 1);
      reset = 1'b0;
      #1;
      check("ra_strobe", {mem_read, mem_write}, 0);
      check("ra_busy", busy, 0);
      check("ra_ack", core_ack, 0);
      check("ra_stall", core_stall, 1);
      tick();
      reset = 1'b1;
      tick();
      check("ra_regrant_addr", mem_address, 8'h07);
      check("ra_regrant_rd", mem_read, 1);
      tick(); tick();
      check("ra_ack_after", core_ack, 1);
      check("ra_data_after", core_data_in, 16'h7777);
      tick();
      core_req = 0;

      // Latency 1: back-to-back core loads, one every three cycles.
      c1_req = 1; c1_address = 8'h40;
      for (int i = 0; i < 3; i++) begin
         logic [7:0] a;
         a = 8'h40 + 8'(i);
         tick();
         check("l1_acc_rd", {m1_read, m1_write, c1_ack}, 3'b100);
         check("l1_acc_addr", m1_address, a);
         tick();
         check("l1_done_ack", {m1_read, c1_ack}, 2'b01);
         check("l1_done_data", c1_data_in, {8'hA5, a});
         if (i == 2) c1_req = 0;
         else c1_address = a + 8'd1;
         tick();
         check("l1_idle", {m1_read, c1_ack, busy1}, 3'b000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
